// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC parallel-bus engine: state encoding,
// bus widths and the idle (reset) level of every bus control line.
package rtc_pkg;

    localparam int RTC_ADDR_W = 8;
    localparam int RTC_DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_DONE     = 4'd8
    } rtc_state_e;

    typedef struct packed {
        logic                  cs_n;
        logic                  ad_n;
        logic                  rd_n;
        logic                  wr_n;
        logic                  ad_oe;
        logic [RTC_DATA_W-1:0] ad_out;
    } rtc_bus_t;

    localparam rtc_bus_t BUS_IDLE = '{
        cs_n:   1'b1,
        ad_n:   1'b1,
        rd_n:   1'b1,
        wr_n:   1'b1,
        ad_oe:  1'b0,
        ad_out: '0
    };

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that flags the final cycle of a bus phase.
// Reloading on every state change restarts the count at the phase boundary.
module rtc_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Runs one multiplexed address/data cycle on the RTC 8-bit bus per accepted
// request and returns read data plus a one-cycle FRW completion pulse.
module rtc_bus_ctrl
    import rtc_pkg::*;
#(
    parameter int PH_CYC = 4,
    parameter int CNT_W  = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Acceso,
    input  logic       Mod,
    input  logic [6:0] Dir,
    input  logic [7:0] DatoW,
    output logic [7:0] DatoR,
    output logic       FRW,
    output logic       Busy,
    output logic       CS_n,
    output logic       AD_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic [7:0] AD_out,
    output logic       AD_oe,
    input  logic [7:0] AD_in,
    output logic [3:0] state_dbg_o
);

    localparam logic [CNT_W-1:0] PH_RELOAD = CNT_W'(PH_CYC - 1);

    rtc_state_e state_q, state_d;
    logic       armed_q, armed_d;
    logic       mod_q, mod_d;
    logic [6:0] dir_q, dir_d;
    logic [7:0] wdat_q, wdat_d;
    logic [7:0] dator_q, dator_d;
    rtc_bus_t   bus_q, bus_d;
    logic       frw_q, frw_d;
    logic       busy_q, busy_d;
    logic       accept;
    logic       ph_last;
    logic       ph_load;

    // Acceso is a level; arming makes a held request produce one transaction.
    assign accept  = (state_q == ST_IDLE) && armed_q && Acceso;
    assign ph_load = (state_d != state_q);

    rtc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .load_i     (ph_load),
        .load_val_i (PH_RELOAD),
        .last_o     (ph_last)
    );

    always_comb begin
        armed_d = armed_q;
        mod_d   = mod_q;
        dir_d   = dir_q;
        wdat_d  = wdat_q;
        if (accept) begin
            armed_d = 1'b0;
            mod_d   = Mod;
            dir_d   = Dir;
            wdat_d  = DatoW;
        end else if (!Acceso) begin
            armed_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept)  state_d = ST_A_SETUP;
            ST_A_SETUP:  if (ph_last) state_d = ST_A_STROBE;
            ST_A_STROBE: if (ph_last) state_d = ST_A_HOLD;
            ST_A_HOLD:   if (ph_last) state_d = ST_GAP;
            ST_GAP:      if (ph_last) state_d = ST_D_SETUP;
            ST_D_SETUP:  if (ph_last) state_d = ST_D_STROBE;
            ST_D_STROBE: if (ph_last) state_d = ST_D_HOLD;
            ST_D_HOLD:   if (ph_last) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registers hold the
    // levels of the state being entered.
    always_comb begin
        bus_d  = BUS_IDLE;
        frw_d  = 1'b0;
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
                bus_d.cs_n   = 1'b0;
                bus_d.ad_n   = 1'b0;
                bus_d.ad_oe  = 1'b1;
                bus_d.ad_out = {1'b0, dir_d};
                bus_d.wr_n   = (state_d != ST_A_STROBE);
            end
            ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
                bus_d.cs_n   = 1'b0;
                bus_d.ad_n   = 1'b1;
                bus_d.ad_oe  = mod_d;
                bus_d.ad_out = mod_d ? wdat_d : 8'h00;
                if (state_d == ST_D_STROBE) begin
                    if (mod_d) bus_d.wr_n = 1'b0;
                    else       bus_d.rd_n = 1'b0;
                end
            end
            ST_DONE: frw_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        dator_d = dator_q;
        if ((state_q == ST_D_STROBE) && ph_last && !mod_q) begin
            dator_d = AD_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            armed_q <= 1'b0;
            mod_q   <= 1'b0;
            dir_q   <= '0;
            wdat_q  <= '0;
            dator_q <= '0;
            bus_q   <= BUS_IDLE;
            frw_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            mod_q   <= mod_d;
            dir_q   <= dir_d;
            wdat_q  <= wdat_d;
            dator_q <= dator_d;
            bus_q   <= bus_d;
            frw_q   <= frw_d;
            busy_q  <= busy_d;
        end
    end

    assign CS_n        = bus_q.cs_n;
    assign AD_n        = bus_q.ad_n;
    assign RD_n        = bus_q.rd_n;
    assign WR_n        = bus_q.wr_n;
    assign AD_oe       = bus_q.ad_oe;
    assign AD_out      = bus_q.ad_out;
    assign DatoR       = dator_q;
    assign FRW         = frw_q;
    assign Busy        = busy_q;
    assign state_dbg_o = state_q;

endmodule
